// File: rtl/vga_image_window_if.sv
// vga_image_window_if: frame RAM read port, VGA pin outputs and buffer-swap handshake.
interface vga_image_window_if #(
    parameter int PIX_W  = 3,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [PIX_W-1:0]  rd_data;
    logic [PIX_W-1:0]  pixel;
    logic              hsync_out;
    logic              vsync_out;
    logic              frame_start;
    logic              swap_req;
    logic              swap_ack;
    modport master (
        output rd_addr, rd_en, pixel, hsync_out, vsync_out, frame_start, swap_ack,
        input  rd_data, swap_req
    );
    modport slave (
        input  rd_addr, rd_en, pixel, hsync_out, vsync_out, frame_start, swap_ack,
        output rd_data, swap_req
    );
endinterface

// File: rtl/vga_image_window.sv
// vga_image_window: VGA timing with a windowed, integer-replicated image read from a sync-read frame RAM.
// Define DOUBLE_BUFFER_EN to enable frame-boundary swapping between two image buffers.
module vga_image_window #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int SCALE    = 1,
    parameter int PIX_W    = 3,
    parameter int ADDR_W   = 13,
    parameter logic [PIX_W-1:0] BG_COLOR = 3'b010
) (
    input logic clk,
    input logic reset,
    vga_image_window_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [2:0] S_LAST = 3'(SCALE - 1);
    localparam logic [ADDR_W-1:0] BUF1 = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] LINE = ADDR_W'(IMG_W);
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic run, buf_sel, swap;
    logic h_end, v_end, in_wx, in_wy, active, win;
    logic [2:0] h_rep, v_rep;
    logic [ADDR_W-1:0] col, line_base;
    logic win1, act1, hs1, vs1, fs1;
    assign h_end  = int'(h_cnt) == H_TOTAL - 1;
    assign v_end  = int'(v_cnt) == V_TOTAL - 1;
    assign active = run && int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE;
    assign in_wx  = int'(h_cnt) >= X0 && int'(h_cnt) < X0 + IMG_W * SCALE;
    assign in_wy  = int'(v_cnt) >= Y0 && int'(v_cnt) < Y0 + IMG_H * SCALE;
    assign win    = active && in_wx && in_wy;
    assign bus.rd_en    = win;
    assign bus.rd_addr  = (buf_sel ? BUF1 : '0) + line_base + col;
    assign bus.swap_ack = swap;
    // run holds the counters at (0,0) for the first clock after reset release
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            run   <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                h_cnt <= h_end ? '0 : h_cnt + 1'b1;
                if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end
        end
    // Incremental addressing; window lines clipped off-screen still advance line_base
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            h_rep     <= '0;
            col       <= '0;
            v_rep     <= '0;
            line_base <= '0;
        end else if (run) begin
            h_rep <= (!in_wx || h_rep == S_LAST) ? '0 : h_rep + 1'b1;
            col   <= !in_wx ? '0 : col + ADDR_W'(h_rep == S_LAST);
            if (h_end && v_end) begin
                v_rep     <= '0;
                line_base <= '0;
            end else if (h_end && in_wy) begin
                v_rep     <= v_rep == S_LAST ? '0 : v_rep + 1'b1;
                line_base <= line_base + (v_rep == S_LAST ? LINE : '0);
            end
        end
`ifdef DOUBLE_BUFFER_EN
    logic pend;
    // A request seen at any time mid-frame is held until the last clock of the frame
    assign swap = run && h_end && v_end && (bus.swap_req || pend);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            buf_sel <= 1'b0;
            pend    <= 1'b0;
        end else begin
            buf_sel <= buf_sel ^ swap;
            pend    <= (pend || bus.swap_req) && !swap;
        end
`else
    logic unused_swap_req;
    assign unused_swap_req = bus.swap_req;
    assign swap    = 1'b0;
    assign buf_sel = 1'b0;
`endif
    // Stage 1 waits out the RAM read; stage 2 drives the pins
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            win1            <= 1'b0;
            act1            <= 1'b0;
            hs1             <= 1'b1;
            vs1             <= 1'b1;
            fs1             <= 1'b0;
            bus.pixel       <= '0;
            bus.hsync_out   <= 1'b1;
            bus.vsync_out   <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            win1            <= win;
            act1            <= active;
            hs1             <= !(int'(h_cnt) >= H_ACTIVE + H_FP && int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
            vs1             <= !(int'(v_cnt) >= V_ACTIVE + V_FP && int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
            fs1             <= run && h_cnt == '0 && v_cnt == '0;
            bus.pixel       <= win1 ? bus.rd_data : act1 ? BG_COLOR : '0;
            bus.hsync_out   <= hs1;
            bus.vsync_out   <= vs1;
            bus.frame_start <= fs1;
        end
endmodule
